// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller: state encoding,
// opcodes, ALUOp codes, operand-select and branch-type codes.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_EX_R   = 4'd2,
      S_EX_I   = 4'd3,
      S_ADDR   = 4'd4,
      S_MEM_RD = 4'd5,
      S_MEM_WR = 4'd6,
      S_WB_ALU = 4'd7,
      S_WB_MEM = 4'd8,
      S_BR     = 4'd9
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_BGE   = 6'b000001;
   localparam logic [5:0] OP_BGT   = 6'b000111;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_SLT   = 3'b010;
   localparam logic [2:0] ALU_RTYPE = 3'b100;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

   localparam logic [1:0] BT_BEQ = 2'b00;
   localparam logic [1:0] BT_BNE = 2'b01;
   localparam logic [1:0] BT_BGE = 2'b10;
   localparam logic [1:0] BT_BGT = 2'b11;

   // States in which the controller may stall on the unified memory.
   function automatic logic is_wait_state(input state_e s);
      return (s == S_IF) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter. Ports: clk_i, rst_i (async, active-high),
// clr_i (restart), inc_i (one more wait cycle), expired_o (count == WAIT_MAX).
module mc_wait_timer #(
   parameter int WAIT_MAX = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam int W = $clog2(WAIT_MAX + 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != W'(WAIT_MAX))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == W'(WAIT_MAX));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller (Moore FSM with memory-wait timeout).
// Ports: clk_i, rst_i (async, active-high), instr_op_i, mem_ready_i in;
// datapath control strobes/selects, state_o, illegal_o, timeout_o out.
// Define EXT_BRANCH_EN to decode bge (000001) and bgt (000111).
module multicycle_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int WAIT_MAX = 15
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] instr_op_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       pc_write_cond_o,
   output logic       ir_write_o,
   output logic       i_or_d_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       mem_to_reg_o,
   output logic       reg_dst_o,
   output logic       reg_write_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [1:0] pc_src_o,
   output logic [2:0] alu_op_o,
   output logic [1:0] branch_type_o,
   output logic [3:0] state_o,
   output logic       illegal_o,
   output logic       timeout_o
);

   state_e state_q, state_d;
   logic   wait_st;
   logic   expired;
   logic   tmo;

   assign wait_st = is_wait_state(state_q);
   assign tmo     = wait_st & expired;

   // Counter restarts whenever the FSM moves, or after a timeout
   // (which may leave the FSM in IF, i.e. no state change).
   mc_wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wait_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     ((state_d != state_q) | tmo),
      .inc_i     (wait_st & ~mem_ready_i & ~tmo),
      .expired_o (expired)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IF;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      ir_write_o      = 1'b0;
      i_or_d_o        = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      mem_to_reg_o    = 1'b0;
      reg_dst_o       = 1'b0;
      reg_write_o     = 1'b0;
      alu_src_a_o     = 1'b0;
      alu_src_b_o     = SRCB_REG;
      pc_src_o        = PCSRC_ALU;
      alu_op_o        = ALU_ADD;
      branch_type_o   = BT_BEQ;
      illegal_o       = 1'b0;

      unique case (state_q)
         S_IF: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = SRCB_FOUR;
            if (tmo) begin
               state_d = S_IF;
            end else if (mem_ready_i) begin
               ir_write_o = 1'b1;
               pc_write_o = 1'b1;
               state_d    = S_ID;
            end
         end
         S_ID: begin
            alu_src_b_o = SRCB_IMM_SH;
            case (instr_op_i)
               OP_RTYPE:        state_d = S_EX_R;
               OP_ADDI, OP_SLTI: state_d = S_EX_I;
               OP_LW, OP_SW:    state_d = S_ADDR;
               OP_BEQ, OP_BNE:  state_d = S_BR;
`ifdef EXT_BRANCH_EN
               OP_BGE, OP_BGT:  state_d = S_BR;
`endif
               default: begin
                  illegal_o = 1'b1;
                  state_d   = S_IF;
               end
            endcase
         end
         S_EX_R: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALU_RTYPE;
            state_d     = S_WB_ALU;
         end
         S_EX_I: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_IMM;
            alu_op_o    = (instr_op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
            state_d     = S_WB_ALU;
         end
         S_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_IMM;
            state_d     = (instr_op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            i_or_d_o   = 1'b1;
            mem_read_o = 1'b1;
            if (tmo) begin
               state_d = S_IF;
            end else if (mem_ready_i) begin
               state_d = S_WB_MEM;
            end
         end
         S_MEM_WR: begin
            i_or_d_o    = 1'b1;
            mem_write_o = 1'b1;
            if (tmo || mem_ready_i) begin
               state_d = S_IF;
            end
         end
         S_WB_ALU: begin
            reg_write_o = 1'b1;
            reg_dst_o   = (instr_op_i == OP_RTYPE);
            state_d     = S_IF;
         end
         S_WB_MEM: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 1'b1;
            state_d      = S_IF;
         end
         S_BR: begin
            alu_src_a_o     = 1'b1;
            alu_op_o        = ALU_SUB;
            pc_write_cond_o = 1'b1;
            pc_src_o        = PCSRC_ALUOUT;
            case (instr_op_i)
               OP_BNE:  branch_type_o = BT_BNE;
`ifdef EXT_BRANCH_EN
               OP_BGE:  branch_type_o = BT_BGE;
               OP_BGT:  branch_type_o = BT_BGT;
`endif
               default: branch_type_o = BT_BEQ;
            endcase
            state_d = S_IF;
         end
         default: state_d = S_IF;
      endcase

      // IF strobes follow mem_ready_i combinationally; keep them
      // quiet while reset holds the FSM in IF.
      if (rst_i) begin
         ir_write_o = 1'b0;
         pc_write_o = 1'b0;
      end
   end

   assign state_o   = state_q;
   assign timeout_o = tmo;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver issues per-cycle
// inputs and queues expected outputs; a negedge monitor compares them.
module tb_multicycle_ctrl;
   import mc_ctrl_pkg::*;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       pcwc;
      logic       irw;
      logic       iod;
      logic       mrd;
      logic       mwr;
      logic       m2r;
      logic       rdst;
      logic       rw;
      logic       asa;
      logic [1:0] asb;
      logic [1:0] pcs;
      logic [2:0] aop;
      logic [1:0] bt;
      logic       ill;
      logic       to;
   } out_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic       rdy;

   logic       pc_write, pc_write_cond, ir_write, i_or_d;
   logic       mem_read, mem_write, mem_to_reg, reg_dst;
   logic       reg_write, alu_src_a;
   logic [1:0] alu_src_b, pc_src, branch_type;
   logic [2:0] alu_op;
   logic [3:0] state;
   logic       illegal, timeout;

   out_t  act;
   out_t  exp_q[$];
   string nm_q[$];
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.WAIT_MAX(15)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .instr_op_i      (op),
      .mem_ready_i     (rdy),
      .pc_write_o      (pc_write),
      .pc_write_cond_o (pc_write_cond),
      .ir_write_o      (ir_write),
      .i_or_d_o        (i_or_d),
      .mem_read_o      (mem_read),
      .mem_write_o     (mem_write),
      .mem_to_reg_o    (mem_to_reg),
      .reg_dst_o       (reg_dst),
      .reg_write_o     (reg_write),
      .alu_src_a_o     (alu_src_a),
      .alu_src_b_o     (alu_src_b),
      .pc_src_o        (pc_src),
      .alu_op_o        (alu_op),
      .branch_type_o   (branch_type),
      .state_o         (state),
      .illegal_o       (illegal),
      .timeout_o       (timeout)
   );

   assign act = {state, pc_write, pc_write_cond, ir_write, i_or_d,
                 mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
                 alu_src_a, alu_src_b, pc_src, alu_op, branch_type,
                 illegal, timeout};

   // Hand-written expected output per state.
   function automatic out_t e_if(input logic go, input logic to);
      out_t o = '0;
      o.st = S_IF; o.mrd = 1'b1; o.asb = 2'b01;
      o.irw = go; o.pcw = go; o.to = to;
      return o;
   endfunction

   function automatic out_t e_id(input logic ill);
      out_t o = '0;
      o.st = S_ID; o.asb = 2'b11; o.ill = ill;
      return o;
   endfunction

   function automatic out_t e_exr();
      out_t o = '0;
      o.st = S_EX_R; o.asa = 1'b1; o.aop = 3'b100;
      return o;
   endfunction

   function automatic out_t e_exi(input logic [2:0] aop);
      out_t o = '0;
      o.st = S_EX_I; o.asa = 1'b1; o.asb = 2'b10; o.aop = aop;
      return o;
   endfunction

   function automatic out_t e_addr();
      out_t o = '0;
      o.st = S_ADDR; o.asa = 1'b1; o.asb = 2'b10;
      return o;
   endfunction

   function automatic out_t e_mrd();
      out_t o = '0;
      o.st = S_MEM_RD; o.iod = 1'b1; o.mrd = 1'b1;
      return o;
   endfunction

   function automatic out_t e_mwr();
      out_t o = '0;
      o.st = S_MEM_WR; o.iod = 1'b1; o.mwr = 1'b1;
      return o;
   endfunction

   function automatic out_t e_wba(input logic rdst);
      out_t o = '0;
      o.st = S_WB_ALU; o.rw = 1'b1; o.rdst = rdst;
      return o;
   endfunction

   function automatic out_t e_wbm();
      out_t o = '0;
      o.st = S_WB_MEM; o.rw = 1'b1; o.m2r = 1'b1;
      return o;
   endfunction

   function automatic out_t e_br(input logic [1:0] bt);
      out_t o = '0;
      o.st = S_BR; o.asa = 1'b1; o.aop = 3'b001;
      o.pcwc = 1'b1; o.pcs = 2'b01; o.bt = bt;
      return o;
   endfunction

   function automatic void cmp(input string nm, input out_t a,
                               input out_t e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, a, e);
      end
   endfunction

   task automatic step(input logic [5:0] o, input logic r,
                       input out_t e, input string nm);
      @(posedge clk);
      #1;
      op  = o;
      rdy = r;
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cmp(nm_q.pop_front(), act, exp_q.pop_front());
      end
   end

   initial begin
      rst = 1'b1;
      op  = OP_RTYPE;
      rdy = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      cmp("reset", act, e_if(1'b0, 1'b0));
      @(negedge clk);
      rdy = 1'b0;
      rst = 1'b0;

      // R-type with one fetch wait: 4 cycles + 1 wait
      step(OP_RTYPE, 1'b0, e_if(1'b0, 1'b0), "r_if_wait");
      step(OP_RTYPE, 1'b1, e_if(1'b1, 1'b0), "r_if");
      step(OP_RTYPE, 1'b1, e_id(1'b0), "r_id");
      step(OP_RTYPE, 1'b1, e_exr(), "r_ex");
      step(OP_RTYPE, 1'b1, e_wba(1'b1), "r_wb");

      // addi / slti
      step(OP_ADDI, 1'b1, e_if(1'b1, 1'b0), "addi_if");
      step(OP_ADDI, 1'b1, e_id(1'b0), "addi_id");
      step(OP_ADDI, 1'b1, e_exi(3'b000), "addi_ex");
      step(OP_ADDI, 1'b1, e_wba(1'b0), "addi_wb");
      step(OP_SLTI, 1'b1, e_if(1'b1, 1'b0), "slti_if");
      step(OP_SLTI, 1'b1, e_id(1'b0), "slti_id");
      step(OP_SLTI, 1'b1, e_exi(3'b010), "slti_ex");
      step(OP_SLTI, 1'b1, e_wba(1'b0), "slti_wb");

      // lw with two MEM_RD waits: 7 cycles
      step(OP_LW, 1'b1, e_if(1'b1, 1'b0), "lw_if");
      step(OP_LW, 1'b1, e_id(1'b0), "lw_id");
      step(OP_LW, 1'b1, e_addr(), "lw_addr");
      step(OP_LW, 1'b0, e_mrd(), "lw_mem_w1");
      step(OP_LW, 1'b0, e_mrd(), "lw_mem_w2");
      step(OP_LW, 1'b1, e_mrd(), "lw_mem");
      step(OP_LW, 1'b1, e_wbm(), "lw_wb");

      // sw
      step(OP_SW, 1'b1, e_if(1'b1, 1'b0), "sw_if");
      step(OP_SW, 1'b1, e_id(1'b0), "sw_id");
      step(OP_SW, 1'b1, e_addr(), "sw_addr");
      step(OP_SW, 1'b1, e_mwr(), "sw_mem");

      // beq / bne
      step(OP_BEQ, 1'b1, e_if(1'b1, 1'b0), "beq_if");
      step(OP_BEQ, 1'b1, e_id(1'b0), "beq_id");
      step(OP_BEQ, 1'b1, e_br(2'b00), "beq_br");
      step(OP_BNE, 1'b1, e_if(1'b1, 1'b0), "bne_if");
      step(OP_BNE, 1'b1, e_id(1'b0), "bne_id");
      step(OP_BNE, 1'b1, e_br(2'b01), "bne_br");

      // bgt / bge: legal only with the extension
      step(OP_BGT, 1'b1, e_if(1'b1, 1'b0), "bgt_if");
`ifdef EXT_BRANCH_EN
      step(OP_BGT, 1'b1, e_id(1'b0), "bgt_id");
      step(OP_BGT, 1'b1, e_br(2'b11), "bgt_br");
      step(OP_BGE, 1'b1, e_if(1'b1, 1'b0), "bge_if");
      step(OP_BGE, 1'b1, e_id(1'b0), "bge_id");
      step(OP_BGE, 1'b1, e_br(2'b10), "bge_br");
`else
      step(OP_BGT, 1'b1, e_id(1'b1), "bgt_illegal");
      step(OP_BGE, 1'b1, e_if(1'b1, 1'b0), "bge_if");
      step(OP_BGE, 1'b1, e_id(1'b1), "bge_illegal");
`endif

      // unknown opcode
      step(6'b111111, 1'b1, e_if(1'b1, 1'b0), "ill_if");
      step(6'b111111, 1'b1, e_id(1'b1), "ill_id");

      // fetch timeout: 15 waits, pulse on the 16th IF cycle even with
      // mem_ready high, then a clean fetch
      for (int i = 0; i < 15; i++) begin
         step(OP_BEQ, 1'b0, e_if(1'b0, 1'b0), "to_wait");
      end
      step(OP_BEQ, 1'b1, e_if(1'b0, 1'b1), "to_pulse");
      step(OP_BEQ, 1'b1, e_if(1'b1, 1'b0), "to_refetch");
      step(OP_BEQ, 1'b1, e_id(1'b0), "to_id");
      step(OP_BEQ, 1'b1, e_br(2'b00), "to_br");

      // async reset in the middle of a stalled MEM_WR
      step(OP_SW, 1'b1, e_if(1'b1, 1'b0), "rst_sw_if");
      step(OP_SW, 1'b1, e_id(1'b0), "rst_sw_id");
      step(OP_SW, 1'b1, e_addr(), "rst_sw_addr");
      @(posedge clk);
      #1;
      rdy = 1'b0;
      cmp("rst_pre_mwr", act, e_mwr());
      #2;
      rst = 1'b1;
      #1;
      cmp("rst_async", act, e_if(1'b0, 1'b0));
      @(negedge clk);
      rst = 1'b0;
      step(OP_SW, 1'b0, e_if(1'b0, 1'b0), "post_rst_if");
      step(OP_BEQ, 1'b1, e_if(1'b1, 1'b0), "post_rst_fetch");
      step(OP_BEQ, 1'b1, e_id(1'b0), "post_rst_id");
      step(OP_BEQ, 1'b1, e_br(2'b00), "post_rst_br");

      for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
         @(posedge clk);
      end
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain pending %0d required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog time %0t required finish", $time);
      $fatal(1);
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter: WAIT_MAX, default 15, maximum consecutive cycles a memory access may wait for mem_ready_i before timeout.
REQ-002 SHALL have port: clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: instr_op_i  input  6  opcode field from instruction register.
REQ-005 SHALL have port: mem_ready_i  input  1  unified memory completes current access this cycle.
REQ-006 SHALL have ports: pc_write_o, pc_write_cond_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o  output  1 each  multicycle datapath controls.
REQ-007 SHALL have ports: alu_src_b_o  output  2 (00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2); pc_src_o  output  2 (00 ALU result, 01 ALUOut register); alu_op_o  output  3; branch_type_o  output  2.
REQ-008 SHALL have ports: state_o  output  4  current state; illegal_o  output  1  one-cycle pulse; timeout_o  output  1  one-cycle pulse.

Function
REQ-009 SHALL implement Moore FSM, states: IF, ID, EX_R, EX_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BR.
REQ-010 IF SHALL drive mem_read_o=1, i_or_d_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=000; ir_write_o and pc_write_o SHALL be 1 only in the cycle mem_ready_i=1, then go to ID; else stay in IF.
REQ-011 ID SHALL drive alu_src_a_o=0, alu_src_b_o=11, alu_op_o=000 (branch target precompute) and dispatch on instr_op_i: 000000->EX_R; 001000/001010->EX_I; 100011/101011->ADDR; 000100/000101->BR; any other -> IF with illegal_o=1 for one cycle.
REQ-012 EX_R SHALL drive alu_src_a_o=1, alu_src_b_o=00, alu_op_o=100 -> WB_ALU with reg_dst_o=1, reg_write_o=1.
REQ-013 EX_I SHALL drive alu_src_a_o=1, alu_src_b_o=10, alu_op_o=000 (addi) or 010 (slti) -> WB_ALU with reg_dst_o=0, reg_write_o=1.
REQ-014 ADDR SHALL drive alu_src_a_o=1, alu_src_b_o=10, alu_op_o=000 -> MEM_RD (lw) or MEM_WR (sw).
REQ-015 MEM_RD/MEM_WR SHALL drive i_or_d_o=1 with mem_read_o/mem_write_o=1 and hold until mem_ready_i=1; MEM_RD then -> WB_MEM (mem_to_reg_o=1, reg_write_o=1); MEM_WR then -> IF.
REQ-016 BR SHALL drive alu_src_a_o=1, alu_src_b_o=00, alu_op_o=001, pc_write_cond_o=1, pc_src_o=01, branch_type_o = 00 beq, 01 bne, 10 bge, 11 bgt -> IF.
REQ-017 WB_ALU and WB_MEM SHALL go to IF; reg_write_o SHALL be 1 only in WB states.
REQ-018 Instruction latency SHALL be 3 cycles branch, 4 R/addi/slti/sw, 5 lw, plus one per memory wait cycle.
REQ-019 Wait counter SHALL count consecutive mem_ready_i=0 cycles in IF/MEM_RD/MEM_WR, clear on state change; on reaching WAIT_MAX it SHALL pulse timeout_o and go to IF without asserting ir_write_o, pc_write_o or reg_write_o.
REQ-020 All controls not listed for a state SHALL be 0; mem_read_o and mem_write_o SHALL never both be 1.

Reset
REQ-021 rst_i=1 SHALL force state IF and counter 0 immediately, independent of clk_i.
REQ-022 During reset all outputs SHALL be 0 except mem_read_o=1 and alu_src_b_o=01 (IF encoding); illegal_o and timeout_o SHALL be 0.
REQ-023 Reset asserted mid-instruction SHALL abort it; no reg_write_o, mem_write_o or pc_write_o from the aborted instruction after release.

Configuration
REQ-024 Macro EXT_BRANCH_EN defined: opcodes 000001 (bge) and 000111 (bgt) SHALL dispatch to BR with branch_type_o 10/11.
REQ-025 EXT_BRANCH_EN undefined: those opcodes SHALL be illegal per REQ-011; branch_type_o SHALL only take 00/01.

Structure
REQ-026 Shared package mc_ctrl_pkg SHALL hold state enum, opcode constants, ALUOp constants (000 add, 001 sub, 010 slt, 100 R-type) and branch_type constants.
REQ-027 Wait counter and timeout compare SHALL be sub-module mc_wait_timer (width clog2(WAIT_MAX+1)).

Verification
REQ-028 mem_ready_i=1 always, op 000000 -> states IF,ID,EX_R,WB_ALU; reg_write_o=1 only in cycle 4.
REQ-029 op 100011, mem_ready_i low 2 cycles in MEM_RD -> 7-cycle instruction, mem_to_reg_o=1 in WB_MEM only.
REQ-030 op 000111 -> with EXT_BRANCH_EN: BR, branch_type_o=11, pc_write_cond_o=1; without: illegal_o pulse, back to IF after ID.
REQ-031 mem_ready_i held 0 in IF, WAIT_MAX=15 -> timeout_o pulse after 15th wait cycle, ir_write_o never 1, return to IF.
REQ-032 rst_i asserted asynchronously mid-cycle in MEM_WR -> state_o=IF before next clock edge, mem_write_o=0 immediately.
